uart_hash_rx: RTL
=================

UART_HASH_RX -- requirements
Module: uart_hash_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit (minimum 4, even).
REQ-002 The module SHALL have parameter DATA_W, default 128, meaning assembled word width in bits (multiple of 8, 8..512).
REQ-003 The module SHALL have parameter TIMEOUT_CLKS, default 65536, meaning idle cycles before a partial word is discarded (used only with UART_HASH_RX_TIMEOUT_EN).
REQ-004 The module SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 The module SHALL have port rs232rx, input, 1, asynchronous UART line (8N1, idle high).
REQ-007 The module SHALL have port hash_out, output, DATA_W, last completed word.
REQ-008 The module SHALL have port hash_valid, output, 1, hash_out holds an unconsumed word.
REQ-009 The module SHALL have port hash_ack, input, 1, consumer accepts word when high with hash_valid.
REQ-010 The module SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 The module SHALL have port overrun, output, 1, one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-012 rs232rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE -> START on synchronized line low; START samples at CLKS_PER_BIT/2 cycles: low -> DATA, high -> IDLE (glitch rejected, nothing counted).
REQ-015 DATA SHALL sample 8 bits LSB first, each CLKS_PER_BIT cycles after the previous sample, then enter STOP.
REQ-016 STOP samples CLKS_PER_BIT cycles after bit 7: high -> byte accepted, IDLE; low -> byte discarded, frame_err pulse, WAIT_HIGH.
REQ-017 WAIT_HIGH -> IDLE on first synchronized high; a frame error SHALL NOT change the byte count or assembly register.
REQ-018 Accepted bytes SHALL shift into an internal DATA_W assembly register from the LSB end, so the first byte of a word lands in bits [DATA_W-1:DATA_W-8].
REQ-019 A byte counter SHALL count 0..DATA_W/8-1 and wrap to 0 when the word completes.
REQ-020 On the cycle after the last byte's stop sample, hash_out SHALL load the assembly register and hash_valid SHALL go 1.
REQ-021 hash_out SHALL remain stable while hash_valid is 1, except when a new word completes.
REQ-022 hash_valid SHALL clear the cycle after hash_valid and hash_ack are both 1; hash_ack with hash_valid low is ignored.
REQ-023 Reception SHALL continue while hash_valid is 1; completion with hash_valid 1 and no ack that cycle overwrites hash_out, keeps hash_valid 1, pulses overrun.
REQ-024 Completion coinciding with hash_ack SHALL load the new word, keep hash_valid 1, and SHALL NOT pulse overrun.

Reset
REQ-025 While rst is high: hash_out=0, hash_valid=0, frame_err=0, overrun=0, FSM=IDLE, byte and bit counters=0, assembly register=0, synchronizer flops=1.
REQ-026 rst asserted mid-byte or mid-word SHALL discard all partial data; the first frame starting after release SHALL be byte 0.

Configuration
REQ-027 With macro UART_HASH_RX_TIMEOUT_EN defined, an idle counter SHALL clear the byte count and assembly register after TIMEOUT_CLKS consecutive IDLE cycles with byte count nonzero; hash_out and hash_valid are unaffected.
REQ-028 Without UART_HASH_RX_TIMEOUT_EN, no timeout logic SHALL exist; a partial word persists until completed or reset.

Verification
REQ-029 CLKS_PER_BIT=16, DATA_W=128: send bytes c1 fe 32 2e 29 ac db fd 71 2b 43 b9 62 47 e7 71 -> hash_out=128'hc1fe322e29acdbfd712b43b96247e771, hash_valid=1 one cycle after 16th stop sample.
REQ-030 Send 0x55 with stop bit 0 -> frame_err high exactly 1 cycle, byte count unchanged; next 16 good bytes form a correct word.
REQ-031 Drive rs232rx low for 4 cycles then high -> no byte accepted, FSM back to IDLE, no frame_err.
REQ-032 Complete word A, no ack, complete word B -> overrun 1-cycle pulse, hash_out=B; ack on B's completion cycle -> no overrun, hash_valid stays 1.
REQ-033 Assert rst during bit 4 of byte 7 -> all outputs 0 next cycle; subsequent 16 bytes form a correct word.
REQ-034 With UART_HASH_RX_TIMEOUT_EN, TIMEOUT_CLKS=1000: send 5 bytes, idle 1000 cycles, send 16 bytes -> hash_out equals those 16 bytes only.

Source files
------------

// File: rtl/uart_hash_rx.sv
// uart_hash_rx: 8N1 UART receiver that packs accepted bytes into DATA_W-bit words.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous, active-high reset
//   rs232rx    - asynchronous UART line (idle high)
//   hash_out   - last completed word (first byte received sits in the top byte)
//   hash_valid - hash_out holds a word the consumer has not yet taken
//   hash_ack   - consumer takes the word when high together with hash_valid
//   frame_err  - one-cycle pulse when a stop bit samples low
//   overrun    - one-cycle pulse when an unconsumed word is overwritten
//
// Optional feature: define UART_HASH_RX_TIMEOUT_EN to discard a partial word after
// TIMEOUT_CLKS consecutive idle cycles. Without it a partial word persists until
// completed or reset.
module uart_hash_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned TIMEOUT_CLKS = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs232rx,
    output logic [DATA_W-1:0] hash_out,
    output logic              hash_valid,
    input  logic              hash_ack,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FullLast = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] ByteLast = BCNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e              state_q, state_d;
    logic                rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]   asm_q, asm_d, asm_shifted;
    logic [DATA_W-1:0]   hash_out_q, hash_out_d;
    logic                hash_valid_q, hash_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic                start_sample, bit_sample, stop_sample, cnt_clr;
    logic                byte_ok, word_done, timeout;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rs232rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!rx_sync_q) state_d = StStart;
            StStart:    if (start_sample) state_d = rx_sync_q ? StIdle : StData;
            StData:     if (bit_sample && bit_idx_q == 3'd7) state_d = StStop;
            StStop:     if (stop_sample) state_d = rx_sync_q ? StIdle : StWaitHigh;
            StWaitHigh: if (rx_sync_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM: sample strobes
    always_comb begin
        start_sample = 1'b0;
        bit_sample   = 1'b0;
        stop_sample  = 1'b0;
        cnt_clr      = 1'b0;
        unique case (state_q)
            StIdle, StWaitHigh: cnt_clr = 1'b1;
            StStart:            start_sample = (cnt_q == HalfLast);
            StData:             bit_sample = (cnt_q == FullLast);
            StStop:             stop_sample = (cnt_q == FullLast);
            default:            cnt_clr = 1'b1;
        endcase
    end

`ifdef UART_HASH_RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CLKS + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Runs only while idle with a partial word held; any activity restarts it.
    always_comb begin
        idle_cnt_d = '0;
        timeout    = 1'b0;
        if (state_q == StIdle && byte_cnt_q != '0) begin
            if (idle_cnt_q == IDLE_W'(TIMEOUT_CLKS - 1)) timeout = 1'b1;
            else idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_cnt_q <= '0;
        else     idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout = 1'b0;
    if (TIMEOUT_CLKS == 0) begin : g_no_timeout
    end
`endif

    assign byte_ok     = stop_sample && rx_sync_q;
    assign word_done   = byte_ok && (byte_cnt_q == ByteLast);
    assign asm_shifted = (asm_q << 8) | DATA_W'(shift_q);

    // Datapath next state
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        hash_out_d   = hash_out_q;
        hash_valid_d = hash_valid_q;
        frame_err_d  = stop_sample && !rx_sync_q;
        overrun_d    = 1'b0;

        if (cnt_clr || start_sample || bit_sample || stop_sample) cnt_d = '0;
        if (state_q == StStart) bit_idx_d = 3'd0;
        if (bit_sample) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
        end
        if (byte_ok) begin
            asm_d      = asm_shifted;
            byte_cnt_d = (byte_cnt_q == ByteLast) ? '0 : byte_cnt_q + BCNT_W'(1);
        end
        if (timeout) begin
            asm_d      = '0;
            byte_cnt_d = '0;
        end

        if (hash_valid_q && hash_ack) hash_valid_d = 1'b0;
        // A completion wins over a same-cycle ack; overrun only if nobody took the old word.
        if (word_done) begin
            hash_out_d   = asm_shifted;
            hash_valid_d = 1'b1;
            overrun_d    = hash_valid_q && !hash_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            hash_out_q   <= '0;
            hash_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            hash_out_q   <= hash_out_d;
            hash_valid_q <= hash_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign hash_out   = hash_out_q;
    assign hash_valid = hash_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
